// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Mode encodings, counter direction type and channel-select width derivation.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A single channel still needs a one-bit select port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow/active pair with write-through at the period boundary,
// comparator against the shared timebase, and a registered output (1 cycle after cnt).
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_sh_d  = wr_hit ? wr_duty : duty_sh_q;
        // Taking the post-write shadow lets a write in the boundary cycle land directly.
        duty_act_d = load ? duty_sh_d : duty_act_q;
        pwm_d      = en && (cnt < duty_act_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned timebase with double-buffered top/mode
// feeding CHANNELS comparators; outputs and period_start are registered (1 cycle after cnt).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    top,
    input  logic                mode,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] top_sh_q, top_act_q;
    logic             mode_sh_q, mode_act_q;
    logic             start_q;
    logic             ps_q;
    logic             bnd;
    logic             load;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_act_q == MODE_EDGE) begin
            dir_d = DIR_UP;
            cnt_d = (cnt_q >= top_act_q) ? '0 : cnt_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= top_act_q) begin
                cnt_d = (top_act_q == '0) ? '0 : top_act_q - 1'b1;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        end

        // A return to zero always opens a new period, whatever the mode.
        bnd = en && (cnt_d == '0);
        if (bnd) begin
            dir_d = DIR_UP;
        end
        load = bnd || !en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            top_sh_q   <= '0;
            mode_sh_q  <= MODE_EDGE;
            top_act_q  <= '0;
            mode_act_q <= MODE_EDGE;
            start_q    <= 1'b1;
            ps_q       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            top_sh_q  <= top;
            mode_sh_q <= mode;
            if (load) begin
                top_act_q  <= top_sh_q;
                mode_act_q <= mode_sh_q;
            end
            // start_q marks the cnt = 0 cycle; registering it lines up with the pwm flops.
            start_q <= load;
            ps_q    <= en && start_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (load),
            .wr_hit  (wr_en && (wr_ch == CH_W'(i))),
            .wr_duty (wr_duty),
            .cnt     (cnt_q),
            .pwm     (pwm[i])
        );
    end

    assign period_start = ps_q;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. It is the successor to the single-channel 3-bit PWM cell.
- A shared timebase counter has a programmable top. It drives CHANNELS independent duty comparators.
- Duty, top and mode are double-buffered (shadow then active) so updates are glitch-free. Edge-aligned and center-aligned modes are supported.
- Sits between the register/control logic and the pad outputs.

Parameters:
- WIDTH, 8, bit width of counter, top and duty values.
- CHANNELS, 4, number of PWM outputs. Must be at least 1.
- CH_W, $clog2(CHANNELS) (minimum 1), width of the channel select (derived).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  timebase enable.
- top  input  WIDTH  period top value; goes into the shadow register every cycle.
- mode  input  1  0 = edge-aligned, 1 = center-aligned; goes into the shadow register every cycle.
- wr_en  input  1  duty write strobe.
- wr_ch  input  CH_W  target channel for the duty write.
- wr_duty  input  WIDTH  duty value to write.
- pwm  output  CHANNELS  registered PWM outputs.
- period_start  output  1  one-cycle pulse on the first cycle of each period.

Behaviour:
- Reset (rst = 1 at an edge):
  - cnt = 0, dir = up.
  - All shadow and active duties = 0.
  - Active top = 0, active mode = 0.
  - pwm = 0, period_start = 0.
  - Reset mid-period aborts the period immediately.
- Shadows:
  - top_sh and mode_sh load every cycle.
  - On wr_en with wr_ch < CHANNELS: duty_sh[wr_ch] <= wr_duty.
  - wr_ch >= CHANNELS is ignored.
- Boundary event B: the cycle in which the next cnt is 0 and a new period begins.
  - On B, every active register loads from its shadow.
  - If a write targets a channel in the same cycle as B, the written value goes straight to active (write-through).
- en = 0:
  - cnt is held at 0, dir = up, pwm = 0, period_start = 0.
  - Shadows copy to active every cycle.
  - Rising edge of en: the first period starts with cnt = 0.
- Edge mode (active mode = 0):
  - cnt sequence is 0, 1, …, top, 0, …; period = top+1 cycles.
  - B when cnt == top.
- Center mode (active mode = 1):
  - cnt sequence is 0, 1, …, top, top-1, …, 1, 0, …; period = 2*top cycles.
  - dir flips to down at top and to up at 0.
  - B when dir = down and cnt == 1.
- top = 0 (either mode): cnt stays 0, B every cycle, period = 1.
- Compare, per channel:
  - pwm[i] <= en && (cnt < duty_act[i]), with 1 cycle latency from cnt.
  - Edge mode: high for min(d, top+1) cycles per period.
  - Center mode, 1 ≤ d ≤ top: high for 2d-1 cycles, centred on cnt = 0.
  - d = 0 gives a constant 0. d > top gives a constant 1.
- period_start <= B && en, so it is aligned with the pwm cycle that shows cnt = 0.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - cnt never exceeds top, so it cannot wrap.
  - If top is reduced mid-period, the change only takes effect at B.
- Latency of a duty write: it takes effect on pwm at the period following the next B, 1 cycle after cnt = 0.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1;
  - the CH_W derivation function.
- Sub-module pwm_channel (one instance per channel) holds the duty shadow and active registers, the write-through logic, the comparator and the output flop.
- pwm_multi holds the timebase counter, dir, the top/mode shadows, and boundary generation.

Test Plan:
- Reset then en = 1, top = 7, mode = 0, ch0 duty = 3 → ch0 high 3 of every 8 cycles; period_start every 8 cycles; other channels low.
- Edge boundaries, top = 7: ch1 duty 0 → constant 0; ch2 duty 8 → constant 1; ch3 duty 255 → constant 1.
- Write ch0 duty 5 mid-period (cnt = 2) → current period keeps 3 high cycles, next period has 5. Repeat with the write in the B cycle → next period has 5 (write-through).
- Center mode, top = 4, duty 2 → period 8, pwm high 3 cycles centred on cnt = 0. Switch mode to 0 mid-period → change applies only after B.
- top = 0, duty 1 → pwm constant 1 and period_start every cycle. Then drop en → pwm = 0 next cycle and cnt = 0.
- Assert rst mid-period with nonzero duties → next cycle all outputs 0 and active duties 0; wr_ch = CHANNELS is ignored.
